// File: rtl/fetch_queue_dual.sv
// Dual-issue fetch front end: paired instruction fetch, J/JAL/BEQ/BNE predecode with
// static prediction, and a circular instruction queue feeding decode 0..2 per cycle.
module fetch_queue_dual #(
  parameter int unsigned AW        = 10,
  parameter int unsigned IW        = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PRED_MODE = 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_en,
  output logic [AW-1:0] imem_addr_a,
  output logic [AW-1:0] imem_addr_b,
  input  logic [IW-1:0] imem_q_a,
  input  logic [IW-1:0] imem_q_b,
  input  logic          redirect_en,
  input  logic [AW-1:0] redirect_pc,
  input  logic [1:0]    deq_cnt,
  output logic [1:0]    out_valid,
  output logic [IW-1:0] out0_instr,
  output logic [IW-1:0] out1_instr,
  output logic [AW-1:0] out0_pc,
  output logic [AW-1:0] out1_pc,
  output logic          out0_taken,
  output logic          out1_taken,
  output logic [AW-1:0] out0_target,
  output logic [AW-1:0] out1_target
);

  localparam int unsigned PTRW = $clog2(DEPTH);
  localparam int unsigned CNTW = PTRW + 1;
  localparam int unsigned CW   = PTRW + 2;
  localparam int unsigned EW   = IW + AW + 1 + AW;

  logic [AW-1:0]   pc_q, pc_d;
  logic            req_valid_q, req_valid_d;
  logic [AW-1:0]   req_pc_q, req_pc_d;
  logic [PTRW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [EW-1:0]   ent_q [DEPTH];
  logic [EW-1:0]   ent_d [DEPTH];

  logic            fetch_go_c;
  logic [CW-1:0]   used_c;
  logic [AW:0]     pd0_c, pd1_c;
  logic [AW-1:0]   slot1_pc_c;
  logic            use1_c;
  logic            taken_any_c;
  logic [AW-1:0]   taken_tgt_c;
  logic [1:0]      enq_n_c;
  logic [CNTW-1:0] deq_eff_c;
  logic [PTRW-1:0] head1_c;

  // Returns {taken, target} for one fetched slot.
  function automatic logic [AW:0] predecode(input logic [IW-1:0] instr, input logic [AW-1:0] spc);
    logic [5:0]    op;
    logic [AW-1:0] seq;
    logic          tk;
    logic [AW-1:0] tgt;
    op  = instr[IW-1:IW-6];
    seq = spc + AW'(1);
    tk  = 1'b0;
    tgt = seq;
    case (op)
      6'd2, 6'd3: begin
        tk  = 1'b1;
        tgt = instr[AW-1:0];
      end
      6'd4, 6'd5: begin
        tgt = seq + instr[AW-1:0];
        if (PRED_MODE == 1) tk = 1'b1;
        else if (PRED_MODE == 2) tk = instr[15];
      end
      default: ;
    endcase
    return {tk, tgt};
  endfunction

  assign imem_addr_a = pc_q;
  assign imem_addr_b = pc_q + AW'(1);
  assign imem_en     = fetch_go_c && !rst;

  always_comb begin
    pc_d        = pc_q;
    req_valid_d = 1'b0;
    req_pc_d    = req_pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    ent_d       = ent_q;

    // Credit check: every outstanding request may still deliver two entries.
    used_c     = CW'(count_q) + (req_valid_q ? CW'(2) : CW'(0));
    fetch_go_c = !redirect_en && (used_c <= CW'(DEPTH - 2));

    slot1_pc_c  = req_pc_q + AW'(1);
    pd0_c       = predecode(imem_q_a, req_pc_q);
    pd1_c       = predecode(imem_q_b, slot1_pc_c);
    use1_c      = !req_pc_q[0] && !pd0_c[AW];
    taken_any_c = req_valid_q && (pd0_c[AW] || (use1_c && pd1_c[AW]));
    taken_tgt_c = pd0_c[AW] ? pd0_c[AW-1:0] : pd1_c[AW-1:0];
    enq_n_c     = !req_valid_q ? 2'd0 : (use1_c ? 2'd2 : 2'd1);

    if (CNTW'(deq_cnt) > count_q) deq_eff_c = count_q;
    else                          deq_eff_c = CNTW'(deq_cnt);

    if (redirect_en) begin
      pc_d    = redirect_pc;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (fetch_go_c) begin
        req_valid_d = 1'b1;
        req_pc_d    = pc_q;
        pc_d        = pc_q[0] ? pc_q + AW'(1) : pc_q + AW'(2);
      end
      if (req_valid_q) begin
        ent_d[tail_q] = {imem_q_a, req_pc_q, pd0_c};
        if (use1_c) ent_d[tail_q + PTRW'(1)] = {imem_q_b, slot1_pc_c, pd1_c};
        tail_d = tail_q + PTRW'(enq_n_c);
        // A predicted-taken slot steers fetch and kills the request issued alongside it.
        if (taken_any_c) begin
          pc_d        = taken_tgt_c;
          req_valid_d = 1'b0;
        end
      end
      head_d  = head_q + PTRW'(deq_eff_c);
      count_d = count_q + CNTW'(enq_n_c) - deq_eff_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= '0;
      req_valid_q <= 1'b0;
      req_pc_q    <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      pc_q        <= pc_d;
      req_valid_q <= req_valid_d;
      req_pc_q    <= req_pc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

  // Queue payload needs no reset; count gates its visibility.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  assign head1_c   = head_q + PTRW'(1);
  assign out_valid = {count_q >= CNTW'(2), count_q != '0};
  assign {out0_instr, out0_pc, out0_taken, out0_target} = ent_q[head_q];
  assign {out1_instr, out1_pc, out1_taken, out1_target} = ent_q[head1_c];

endmodule

// File: tb/tb_fetch_queue_dual.sv
// Bench for fetch_queue_dual: one instance per prediction mode, all checked every cycle
// against a queue-based reference model driven by directed and random programs.
module tb_fetch_queue_dual;

  localparam int AW    = 10;
  localparam int IW    = 32;
  localparam int DEPTH = 8;
  localparam int MSZ   = 1 << AW;
  localparam int NI    = 3;

  typedef struct {
    logic [31:0] instr;
    int          pc;
    bit          tk;
    int          tgt;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          redirect_en = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [1:0]    deq_cnt = 2'd0;

  logic          en_s  [NI];
  logic [AW-1:0] aa_s  [NI];
  logic [AW-1:0] ab_s  [NI];
  logic [IW-1:0] qa_s  [NI];
  logic [IW-1:0] qb_s  [NI];
  logic [1:0]    ov_s  [NI];
  logic [IW-1:0] i0_s  [NI];
  logic [IW-1:0] i1_s  [NI];
  logic [AW-1:0] p0_s  [NI];
  logic [AW-1:0] p1_s  [NI];
  logic          t0_s  [NI];
  logic          t1_s  [NI];
  logic [AW-1:0] g0_s  [NI];
  logic [AW-1:0] g1_s  [NI];

  logic [31:0] mem [MSZ];

  int   n_checks = 0;
  int   n_errors = 0;

  int          m_pc  [NI];
  int          m_rv  [NI];
  int          m_rpc [NI];
  logic [31:0] m_ra  [NI];
  logic [31:0] m_rb  [NI];
  ent_t        mq    [NI][$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    fetch_queue_dual #(.AW(AW), .IW(IW), .DEPTH(DEPTH), .PRED_MODE(g)) u_dut (
      .clk(clk), .rst(rst),
      .imem_en(en_s[g]), .imem_addr_a(aa_s[g]), .imem_addr_b(ab_s[g]),
      .imem_q_a(qa_s[g]), .imem_q_b(qb_s[g]),
      .redirect_en(redirect_en), .redirect_pc(redirect_pc), .deq_cnt(deq_cnt),
      .out_valid(ov_s[g]),
      .out0_instr(i0_s[g]), .out1_instr(i1_s[g]),
      .out0_pc(p0_s[g]), .out1_pc(p1_s[g]),
      .out0_taken(t0_s[g]), .out1_taken(t1_s[g]),
      .out0_target(g0_s[g]), .out1_target(g1_s[g])
    );
  end

  // Synchronous dual-port instruction memory, one read port pair per instance.
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (en_s[k]) begin
        qa_s[k] <= mem[aa_s[k]];
        qb_s[k] <= mem[ab_s[k]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_pred(input int mode, input logic [31:0] ins, input int spc,
                                 output bit tk, output int tgt);
    int op;
    int imm;
    op  = int'(ins >> 26);
    imm = int'(ins & 32'h3FF);
    tk  = 1'b0;
    tgt = (spc + 1) % MSZ;
    if (op == 2 || op == 3) begin
      tk  = 1'b1;
      tgt = imm;
    end else if (op == 4 || op == 5) begin
      tgt = (spc + 1 + imm) % MSZ;
      tk  = (mode == 1) || (mode == 2 && ins[15]);
    end
  endfunction

  function automatic bit m_go(input int k);
    return !redirect_en && (DEPTH - mq[k].size() - 2 * m_rv[k]) >= 2;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_pc[k] = 0;
      m_rv[k] = 0;
      m_rpc[k] = 0;
      mq[k].delete();
    end
  endtask

  task automatic model_step(input int k);
    bit   go;
    bit   tk;
    int   tg;
    int   d;
    int   npc;
    int   nrv;
    ent_t e;
    go = m_go(k);
    if (redirect_en) begin
      mq[k].delete();
      m_pc[k] = int'(redirect_pc);
      m_rv[k] = 0;
      return;
    end
    d = (int'(deq_cnt) < mq[k].size()) ? int'(deq_cnt) : mq[k].size();
    repeat (d) void'(mq[k].pop_front());
    npc = m_pc[k];
    nrv = 0;
    if (go) begin
      nrv = 1;
      npc = (m_pc[k] % 2 == 1) ? (m_pc[k] + 1) % MSZ : (m_pc[k] + 2) % MSZ;
    end
    if (m_rv[k] != 0) begin
      m_pred(k, m_ra[k], m_rpc[k], tk, tg);
      e = '{instr: m_ra[k], pc: m_rpc[k], tk: tk, tgt: tg};
      mq[k].push_back(e);
      if (tk) begin
        npc = tg;
        nrv = 0;
      end else if (m_rpc[k] % 2 == 0) begin
        m_pred(k, m_rb[k], (m_rpc[k] + 1) % MSZ, tk, tg);
        e = '{instr: m_rb[k], pc: (m_rpc[k] + 1) % MSZ, tk: tk, tgt: tg};
        mq[k].push_back(e);
        if (tk) begin
          npc = tg;
          nrv = 0;
        end
      end
    end
    if (go) begin
      m_ra[k]  = mem[m_pc[k]];
      m_rb[k]  = mem[(m_pc[k] + 1) % MSZ];
      m_rpc[k] = m_pc[k];
    end
    m_pc[k] = npc;
    m_rv[k] = nrv;
  endtask

  task automatic check_outputs(input int k);
    bit   go;
    int   sz;
    ent_t e;
    go = !rst && m_go(k);
    sz = mq[k].size();
    check($sformatf("m%0d_imem_en", k), 32'(en_s[k]), 32'(go));
    if (go) begin
      check($sformatf("m%0d_addr_a", k), 32'(aa_s[k]), 32'(m_pc[k]));
      check($sformatf("m%0d_addr_b", k), 32'(ab_s[k]), 32'((m_pc[k] + 1) % MSZ));
    end
    check($sformatf("m%0d_out_valid", k), 32'(ov_s[k]), (sz >= 2) ? 32'd3 : 32'(sz));
    if (sz >= 1) begin
      e = mq[k][0];
      check($sformatf("m%0d_out0_instr", k), i0_s[k], e.instr);
      check($sformatf("m%0d_out0_pc", k), 32'(p0_s[k]), 32'(e.pc));
      check($sformatf("m%0d_out0_taken", k), 32'(t0_s[k]), 32'(e.tk));
      check($sformatf("m%0d_out0_target", k), 32'(g0_s[k]), 32'(e.tgt));
    end
    if (sz >= 2) begin
      e = mq[k][1];
      check($sformatf("m%0d_out1_instr", k), i1_s[k], e.instr);
      check($sformatf("m%0d_out1_pc", k), 32'(p1_s[k]), 32'(e.pc));
      check($sformatf("m%0d_out1_taken", k), 32'(t1_s[k]), 32'(e.tk));
      check($sformatf("m%0d_out1_target", k), 32'(g1_s[k]), 32'(e.tgt));
    end
  endtask

  // One clock: drive inputs on the falling edge, check, then advance the model.
  task automatic cyc(input bit r, input bit red, input int rpc, input int dq);
    @(negedge clk);
    rst         = r;
    redirect_en = red;
    redirect_pc = AW'(rpc);
    deq_cnt     = 2'(dq);
    if (r) model_reset();
    #1;
    for (int k = 0; k < NI; k++) check_outputs(k);
    if (!r) for (int k = 0; k < NI; k++) model_step(k);
  endtask

  function automatic logic [31:0] plain(input int a);
    return 32'(a) | 32'h0040_0000;
  endfunction

  task automatic load_plain();
    for (int a = 0; a < MSZ; a++) mem[a] = plain(a);
  endtask

  task automatic load_random();
    logic [31:0] w;
    for (int a = 0; a < MSZ; a++) begin
      w = $urandom();
      if ($urandom_range(0, 99) < 30) w[31:26] = 6'($urandom_range(2, 5));
      else if ($urandom_range(0, 1) == 0) w[31:26] = 6'd0;
      else w[31:26] = 6'($urandom_range(6, 63));
      mem[a] = w;
    end
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 0, 0);
    cyc(1'b1, 1'b0, 0, 0);
  endtask

  initial begin
    model_reset();
    load_plain();

    // Straight-line code drained two per cycle.
    do_reset();
    repeat (12) cyc(1'b0, 1'b0, 0, 2);

    // Unconditional jump at 4 to 0x20.
    mem[4] = (32'd2 << 26) | 32'h0000_0020;
    do_reset();
    repeat (14) cyc(1'b0, 1'b0, 0, 2);

    // Jump response coincides with a backend redirect.
    do_reset();
    repeat (3) cyc(1'b0, 1'b0, 0, 2);
    cyc(1'b0, 1'b1, 32'h50, 2);
    repeat (6) cyc(1'b0, 1'b0, 0, 2);
    mem[4] = plain(4);

    // Backward BEQ at 10 and forward BNE at 12.
    mem[10] = (32'd4 << 26) | 32'h0000_FFFC;
    mem[12] = (32'd5 << 26) | 32'h0000_0003;
    do_reset();
    cyc(1'b0, 1'b1, 10, 0);
    repeat (14) cyc(1'b0, 1'b0, 0, 2);
    mem[10] = plain(10);
    mem[12] = plain(12);

    // Odd entry point.
    do_reset();
    cyc(1'b0, 1'b1, 9, 0);
    repeat (8) cyc(1'b0, 1'b0, 0, 1);

    // Fill to capacity with no consumption, then drain.
    do_reset();
    repeat (14) cyc(1'b0, 1'b0, 0, 0);
    repeat (3) cyc(1'b0, 1'b0, 0, 3);
    repeat (10) cyc(1'b0, 1'b0, 0, 2);

    // Back-to-back redirects, last one wins.
    do_reset();
    repeat (4) cyc(1'b0, 1'b0, 0, 1);
    cyc(1'b0, 1'b1, 100, 1);
    cyc(1'b0, 1'b1, 201, 1);
    repeat (6) cyc(1'b0, 1'b0, 0, 1);

    // Random programs, consumption, redirects and mid-run resets.
    for (int run = 0; run < 4; run++) begin
      load_random();
      do_reset();
      for (int c = 0; c < 1500; c++) begin
        if ($urandom_range(0, 999) < 4)
          cyc(1'b1, 1'b0, 0, 0);
        else
          cyc(1'b0, ($urandom_range(0, 99) < 5), int'($urandom_range(0, MSZ - 1)),
              int'($urandom_range(0, 3)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
